// File: rtl/dsp_bb_pkg.sv
// Shared helpers for the DSP-BB arithmetic blocks: pointer widths, limits and
// full-precision output width derivation.
package dsp_bb_pkg;

   localparam int DELAY_MAX = 256;

   function automatic int ptr_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   function automatic int out_width(input int iwidth);
      return iwidth + 1;
   endfunction

endpackage

// File: rtl/signed_delay_line.sv
// Circular history buffer of DEPTH samples; dout is the oldest entry, read
// asynchronously so the caller can consume it in the same cycle it is overwritten.
module signed_delay_line
   import dsp_bb_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int PW = ptr_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;

   assign dout = mem[wp];

   always_ff @(posedge clk) begin
      if (clr) begin
         wp <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (en) begin
         mem[wp] <= din;
         if (wp == PW'(DEPTH - 1)) begin
            wp <= '0;
         end else begin
            wp <= wp + PW'(1);
         end
      end
   end

endmodule

// File: rtl/signed_comb.sv
// Registered comb stage y[n] = x[n] - x[n-DELAY]; 1-cycle latency, full
// precision output, accepts one sample per cycle with no backpressure.
module signed_comb
   import dsp_bb_pkg::*;
#(
   parameter int  IWIDTH = 16,
   parameter int  DELAY  = 4,
   localparam int OWIDTH = out_width(IWIDTH)
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_valid,
   input  logic signed [IWIDTH-1:0] i_x,
   output logic                     o_valid,
   output logic signed [OWIDTH-1:0] o_diff,
   output logic                     o_primed
);

   localparam int CW = $clog2(DELAY + 1);

   logic [IWIDTH-1:0] old;
   logic [CW-1:0]     prime_cnt;

   signed_delay_line #(
      .WIDTH (IWIDTH),
      .DEPTH (DELAY)
   ) u_hist (
      .clk  (i_clk),
      .clr  (i_reset),
      .en   (i_valid),
      .din  (i_x),
      .dout (old)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid   <= 1'b0;
         o_diff    <= '0;
         o_primed  <= 1'b0;
         prime_cnt <= '0;
      end else begin
         o_valid <= i_valid;
         if (i_valid) begin
            // Sign-extend both operands first so the difference cannot wrap.
            o_diff <= OWIDTH'(i_x) - OWIDTH'($signed(old));
            if (prime_cnt != CW'(DELAY)) begin
               prime_cnt <= prime_cnt + CW'(1);
            end
            if (prime_cnt == CW'(DELAY - 1)) begin
               o_primed <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_signed_comb.sv
// Directed and randomised checks of signed_comb at DELAY=4 and DELAY=1,
// both instances driven from the same stimulus.
module tb_signed_comb;

   logic               clk;
   logic               rst;
   logic               vld;
   logic signed [15:0] x;
   logic               v4, p4, v1, p1;
   logic signed [16:0] d4, d1;

   int total = 0;
   int bad   = 0;

   signed_comb #(.IWIDTH(16), .DELAY(4)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_x(x),
      .o_valid(v4), .o_diff(d4), .o_primed(p4)
   );

   signed_comb #(.IWIDTH(16), .DELAY(1)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_x(x),
      .o_valid(v1), .o_diff(d1), .o_primed(p1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      vld = 1'b0;
      x   = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      vld = 1'b1;
      x   = 16'sd123;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if ({v4, d4, p4} !== 19'd0) begin
            bad++;
            $display("FAIL reset_hold4 cyc=%0d got v=%b d=%0d p=%b want 0/0/0", c, v4, d4, p4);
         end
         total++;
         if ({v1, d1, p1} !== 19'd0) begin
            bad++;
            $display("FAIL reset_hold1 cyc=%0d got v=%b d=%0d p=%b want 0/0/0", c, v1, d1, p1);
         end
      end
      rst = 1'b0;
      vld = 1'b0;
      tick();
      total++;
      if ({v4, d4, p4} !== 19'd0) begin
         bad++;
         $display("FAIL reset_release got v=%b d=%0d p=%b want 0/0/0", v4, d4, p4);
      end
      vld = 1'b1;
      x   = 16'sd7;
      tick();
      vld = 1'b0;
      total++;
      if (v4 !== 1'b1 || d4 !== 17'sd7 || d1 !== 17'sd7) begin
         bad++;
         $display("FAIL reset_first got v=%b d4=%0d d1=%0d want 1/7/7", v4, d4, d1);
      end
   endtask

   task automatic test_ramp();
      logic signed [16:0] e;
      apply_reset();
      for (int n = 0; n < 10; n++) begin
         vld = 1'b1;
         x   = 16'(n);
         tick();
         e = (n < 4) ? 17'(n) : 17'sd4;
         total++;
         if (v4 !== 1'b1 || d4 !== e) begin
            bad++;
            $display("FAIL ramp n=%0d got v=%b d=%0d want 1/%0d", n, v4, d4, e);
         end
         total++;
         if (p4 !== (n >= 3)) begin
            bad++;
            $display("FAIL ramp_primed n=%0d got %b want %b", n, p4, (n >= 3));
         end
      end
      vld = 1'b0;
      tick();
      total++;
      if (v4 !== 1'b0 || d4 !== 17'sd4) begin
         bad++;
         $display("FAIL ramp_end got v=%b d=%0d want 0/4", v4, d4);
      end
   endtask

   task automatic test_extremes();
      logic signed [15:0] xs [3][5];
      logic signed [16:0] es [3][5];
      xs[0] = '{16'sd32767, 16'sd0, 16'sd0, 16'sd0, -16'sd32768};
      es[0] = '{17'sd32767, 17'sd0, 17'sd0, 17'sd0, -17'sd65535};
      xs[1] = '{16'sd32767, 16'sd0, 16'sd0, 16'sd0, 16'sd32767};
      es[1] = '{17'sd32767, 17'sd0, 17'sd0, 17'sd0, 17'sd0};
      xs[2] = '{-16'sd32768, 16'sd0, 16'sd0, 16'sd0, 16'sd32767};
      es[2] = '{-17'sd32768, 17'sd0, 17'sd0, 17'sd0, 17'sd65535};
      for (int s = 0; s < 3; s++) begin
         apply_reset();
         for (int n = 0; n < 5; n++) begin
            vld = 1'b1;
            x   = xs[s][n];
            tick();
            total++;
            if (v4 !== 1'b1 || d4 !== es[s][n]) begin
               bad++;
               $display("FAIL extremes set=%0d n=%0d got v=%b d=%0d want 1/%0d", s, n, v4, d4, es[s][n]);
            end
         end
      end
      vld = 1'b0;
   endtask

   task automatic test_gapped();
      logic signed [16:0] e;
      apply_reset();
      for (int n = 0; n < 8; n++) begin
         vld = 1'b1;
         x   = 16'(n);
         tick();
         e = (n < 4) ? 17'(n) : 17'sd4;
         total++;
         if (v4 !== 1'b1 || d4 !== e) begin
            bad++;
            $display("FAIL gapped n=%0d got v=%b d=%0d want 1/%0d", n, v4, d4, e);
         end
         vld = 1'b0;
         x   = 16'sd999;
         tick();
         total++;
         if (v4 !== 1'b0 || d4 !== e) begin
            bad++;
            $display("FAIL gapped_hold n=%0d got v=%b d=%0d want 0/%0d", n, v4, d4, e);
         end
      end
   endtask

   task automatic test_midreset();
      logic signed [16:0] e;
      apply_reset();
      for (int n = 0; n < 6; n++) begin
         vld = 1'b1;
         x   = 16'(n);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({v4, d4, p4} !== 19'd0) begin
         bad++;
         $display("FAIL midreset_clear got v=%b d=%0d p=%b want 0/0/0", v4, d4, p4);
      end
      for (int n = 0; n < 5; n++) begin
         vld = 1'b1;
         x   = 16'sd10;
         tick();
         e = (n < 4) ? 17'sd10 : 17'sd0;
         total++;
         if (v4 !== 1'b1 || d4 !== e || p4 !== (n >= 3)) begin
            bad++;
            $display("FAIL midreset n=%0d got v=%b d=%0d p=%b want 1/%0d/%b", n, v4, d4, p4, e, (n >= 3));
         end
      end
      vld = 1'b0;
   endtask

   task automatic test_wrap_delay1();
      logic signed [15:0] xs [4];
      logic signed [16:0] es [4];
      xs = '{16'sd5, -16'sd3, -16'sd3, 16'sd100};
      es = '{17'sd5, -17'sd8, 17'sd0, 17'sd103};
      apply_reset();
      for (int n = 0; n < 4; n++) begin
         vld = 1'b1;
         x   = xs[n];
         tick();
         total++;
         if (v1 !== 1'b1 || d1 !== es[n] || p1 !== 1'b1) begin
            bad++;
            $display("FAIL wrap1 n=%0d got v=%b d=%0d p=%b want 1/%0d/1", n, v1, d1, p1, es[n]);
         end
      end
      vld = 1'b0;
   endtask

   task automatic test_random();
      int                 q[$];
      int                 old4, old1;
      logic signed [16:0] e4, e1;
      logic               ev;
      apply_reset();
      e4 = '0;
      e1 = '0;
      for (int n = 0; n < 200; n++) begin
         ev  = ($urandom_range(0, 3) != 0);
         vld = ev;
         x   = 16'($urandom_range(0, 65535));
         if (ev) begin
            old4 = (q.size() >= 4) ? q[q.size() - 4] : 0;
            old1 = (q.size() >= 1) ? q[q.size() - 1] : 0;
            e4 = 17'(int'(x) - old4);
            e1 = 17'(int'(x) - old1);
            q.push_back(int'(x));
         end
         tick();
         total++;
         if (v1 !== ev || d1 !== e1) begin
            bad++;
            $display("FAIL random1 n=%0d got v=%b d=%0d want %b/%0d", n, v1, d1, ev, e1);
         end
         total++;
         if (v4 !== ev || d4 !== e4 || p4 !== (q.size() >= 4)) begin
            bad++;
            $display("FAIL random4 n=%0d got v=%b d=%0d p=%b want %b/%0d/%b", n, v4, d4, p4, ev, e4, (q.size() >= 4));
         end
      end
      vld = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      vld = 1'b0;
      x   = '0;
      test_reset();
      test_ramp();
      test_extremes();
      test_gapped();
      test_midreset();
      test_wrap_delay1();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
